// File: rtl/bufer_ex_mem_if.sv
// EX/MEM buffer bus: EX-side input bundle, MEM-side output bundle,
// and the forwarding/branch taps driven from the head entry.
interface bufer_ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] in_target;
    logic              in_zero;
    logic [REG_W-1:0]  in_rd;
    logic [4:0]        in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_wdata;
    logic [DATA_W-1:0] out_target;
    logic              out_zero;
    logic [REG_W-1:0]  out_rd;
    logic [4:0]        out_ctrl;

    logic              pc_src;
    logic              fwd_regwrite;
    logic [REG_W-1:0]  fwd_rd;

    modport master (
        output in_valid, in_alu, in_wdata, in_target,
        output in_zero, in_rd, in_ctrl, out_ready,
        input  in_ready, out_valid, out_alu, out_wdata,
        input  out_target, out_zero, out_rd, out_ctrl,
        input  pc_src, fwd_regwrite, fwd_rd
    );

    modport slave (
        input  in_valid, in_alu, in_wdata, in_target,
        input  in_zero, in_rd, in_ctrl, out_ready,
        output in_ready, out_valid, out_alu, out_wdata,
        output out_target, out_zero, out_rd, out_ctrl,
        output pc_src, fwd_regwrite, fwd_rd
    );
endinterface

// File: rtl/bufer_ex_mem.sv
// EX/MEM pipeline register: two-entry skid buffer (main + skid)
// with valid/ready handshakes and synchronous flush.
module bufer_ex_mem #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    bufer_ex_mem_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] target;
        logic              zero;
        logic [REG_W-1:0]  rd;
        logic [4:0]        ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t r_state;
    state_t w_next;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_emit;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;

    assign w_main_valid = (r_state != EMPTY);
    assign w_skid_valid = (r_state == FULL);

    // in_ready comes straight from state, never from out_ready
    assign bus.in_ready = !w_skid_valid;

    assign w_accept = bus.in_valid & !w_skid_valid;
    assign w_emit   = w_main_valid & bus.out_ready;

    assign w_in.alu    = bus.in_alu;
    assign w_in.wdata  = bus.in_wdata;
    assign w_in.target = bus.in_target;
    assign w_in.zero   = bus.in_zero;
    assign w_in.rd     = bus.in_rd;
    assign w_in.ctrl   = bus.in_ctrl;

    always_comb begin
        w_next         = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_ld_main_in = 1'b1;
                        w_next       = ONE;
                    end
                end
                ONE: begin
                    if (w_emit && w_accept) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_emit) begin
                        w_next = EMPTY;
                    end else if (w_accept) begin
                        w_ld_skid = 1'b1;
                        w_next    = FULL;
                    end
                end
                FULL: begin
                    if (w_emit) begin
                        w_ld_main_skid = 1'b1;
                        w_next         = ONE;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush leaves data in place; only reset zeroes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main <= w_in;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in;
            end
        end
    end

    assign bus.out_valid  = w_main_valid;
    assign bus.out_alu    = r_main.alu;
    assign bus.out_wdata  = r_main.wdata;
    assign bus.out_target = r_main.target;
    assign bus.out_zero   = r_main.zero;
    assign bus.out_rd     = r_main.rd;
    assign bus.out_ctrl   = r_main.ctrl;

    assign bus.pc_src       = w_main_valid & r_main.ctrl[0] & r_main.zero;
    assign bus.fwd_regwrite = w_main_valid & r_main.ctrl[4];
    assign bus.fwd_rd       = r_main.rd;
endmodule

// File: tb/tb_bufer_ex_mem.sv
// Scoreboard bench for bufer_ex_mem: a queue model of the two
// entries predicts handshakes, head fields and branch/forward taps.
module tb_bufer_ex_mem;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    bufer_ex_mem_if #(.DATA_W(32), .REG_W(5)) bus ();

    bufer_ex_mem #(.DATA_W(32), .REG_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] target;
        logic        zero;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sample mid-cycle, then advance the model for the coming edge
    always @(negedge clk) begin
        ent_t e;
        ent_t h;
        bit   acc;
        bit   em;
        if (!rst_n) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_ready", bus.in_ready, 1);
            chk("rst_alu", bus.out_alu, 0);
            chk("rst_pcsrc", bus.pc_src, 0);
            chk("rst_fwd", bus.fwd_regwrite, 0);
            q.delete();
        end else begin
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, q.size() < 2);
            if (q.size() != 0) begin
                h = q[0];
                chk("out_alu", bus.out_alu, h.alu);
                chk("out_wdata", bus.out_wdata, h.wdata);
                chk("out_target", bus.out_target, h.target);
                chk("out_zero", bus.out_zero, h.zero);
                chk("out_rd", bus.out_rd, h.rd);
                chk("out_ctrl", bus.out_ctrl, h.ctrl);
                chk("pc_src", bus.pc_src, h.ctrl[0] & h.zero);
                chk("fwd_we", bus.fwd_regwrite, h.ctrl[4]);
                chk("fwd_rd", bus.fwd_rd, h.rd);
            end else begin
                chk("pc_src_idle", bus.pc_src, 0);
                chk("fwd_we_idle", bus.fwd_regwrite, 0);
            end
            if (flush) begin
                q.delete();
            end else begin
                acc = bus.in_valid && (q.size() < 2);
                em  = bus.out_ready && (q.size() != 0);
                if (em) void'(q.pop_front());
                if (acc) begin
                    e.alu    = bus.in_alu;
                    e.wdata  = bus.in_wdata;
                    e.target = bus.in_target;
                    e.zero   = bus.in_zero;
                    e.rd     = bus.in_rd;
                    e.ctrl   = bus.in_ctrl;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] alu,
                       input logic [31:0] tg, input logic z,
                       input logic [4:0] rd, input logic [4:0] ctrl);
        bus.in_valid  = v;
        bus.in_alu    = alu;
        bus.in_wdata  = $urandom;
        bus.in_target = tg;
        bus.in_zero   = z;
        bus.in_rd     = rd;
        bus.in_ctrl   = ctrl;
        step();
    endtask

    task automatic send(input logic [31:0] alu);
        put(1'b1, alu, $urandom, 1'b0, 5'($urandom), 5'b00000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            put(1'b0, 32'hDEAD_0000 + i, 32'h0, 1'b1, 5'd31, 5'b10001);
        end
    endtask

    initial begin
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_alu    = 32'h55;
        bus.in_wdata  = 32'h66;
        bus.in_target = 32'h77;
        bus.in_zero   = 1'b1;
        bus.in_rd     = 5'd3;
        bus.in_ctrl   = 5'b10001;
        repeat (2) step();
        rst_n = 1'b1;
        send(32'h55);
        idle(2);

        send(32'h10);
        send(32'h20);
        send(32'h30);
        idle(2);

        bus.out_ready = 1'b0;
        send(32'hA);
        send(32'hB);
        idle(2);
        bus.out_ready = 1'b1;
        idle(3);

        bus.out_ready = 1'b0;
        send(32'h1);
        send(32'h2);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        send(32'hC);
        flush = 1'b0;
        idle(2);

        put(1'b1, 32'h100, 32'h0040_0020, 1'b1, 5'd0, 5'b00001);
        idle(2);
        put(1'b1, 32'h104, 32'h0040_0040, 1'b0, 5'd0, 5'b00001);
        idle(2);

        bus.out_ready = 1'b0;
        put(1'b1, 32'h200, 32'h0, 1'b0, 5'd9, 5'b10000);
        idle(3);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        for (int i = 0; i < 300; i++) begin
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            put(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom), 5'($urandom), 5'($urandom));
        end
        flush = 1'b0;
        bus.out_ready = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain", q.size(), 0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
